// File: rtl/gpr_wb_arb_if.sv
// Writeback bus between the two GPR write sources, the arbiter and the register-file write port.
// A source presents a write with *_valid; it is taken in that cycle when wb_stall=0 and no flush is active,
// and a source seeing wb_stall=1 must hold the write until wb_stall falls (no ready signal exists).
interface gpr_wb_arb_if #(
    parameter int dw = 32,
    parameter int aw = 5
);
    logic          a_valid;
    logic [aw-1:0] a_addr;
    logic [dw-1:0] a_data;
    logic          b_valid;
    logic [aw-1:0] b_addr;
    logic [dw-1:0] b_data;
    logic          rf_we;
    logic [aw-1:0] rf_addrw;
    logic [dw-1:0] rf_dataw;
    logic          wb_stall;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  rf_we, rf_addrw, rf_dataw, wb_stall
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output rf_we, rf_addrw, rf_dataw, wb_stall
    );
endinterface

// File: rtl/gpr_wb_arb.sv
// Merges execute (A) and load/update (B) writebacks onto the single GPR write port,
// buffering overflow in a FIFO and forwarding the newest pending value to the read ports.
module gpr_wb_arb #(
    parameter int dw    = 32,
    parameter int aw    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wb_freeze,
    input  logic                       i_flushpipe,
    gpr_wb_arb_if.slave                bus,
    output logic                       o_ovf,
    output logic [$clog2(DEPTH):0]     o_pend_cnt,
    input  logic [aw-1:0]              i_addra,
    input  logic [aw-1:0]              i_addrb,
    input  logic [aw-1:0]              i_addrc,
    output logic                       o_hita,
    output logic                       o_hitb,
    output logic                       o_hitc,
    output logic [dw-1:0]              o_fwda,
    output logic [dw-1:0]              o_fwdb,
    output logic [dw-1:0]              o_fwdc
);
    localparam int PW = $clog2(DEPTH);

    logic [aw-1:0] r_addr [DEPTH];
    logic [dw-1:0] r_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_cnt;
    logic          r_ovf;

    logic          w_stall;
    logic          w_acc_a, w_acc_b;
    logic          w_pop, w_direct_a, w_direct_b;
    logic          w_push_a, w_push_b;
    logic [PW-1:0] w_wr_ptr_b;
    logic [aw-1:0] w_raddr [3];
    logic          w_hit [3];
    logic [dw-1:0] w_fwd [3];

    // Stall leaves room for a worst-case double push next cycle.
    assign w_stall    = r_cnt > (PW+1)'(DEPTH-2);
    assign w_acc_a    = bus.a_valid & ~i_flushpipe & ~w_stall;
    assign w_acc_b    = bus.b_valid & ~i_flushpipe & ~w_stall;
    assign w_pop      = ~i_wb_freeze & (r_cnt != '0);
    assign w_direct_a = ~i_wb_freeze & (r_cnt == '0) & w_acc_a;
    assign w_direct_b = ~i_wb_freeze & (r_cnt == '0) & ~w_acc_a & w_acc_b;
    assign w_push_a   = w_acc_a & ~w_direct_a;
    assign w_push_b   = w_acc_b & ~w_direct_b;
    assign w_wr_ptr_b = r_wr_ptr + PW'(w_push_a);

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_addrw = '0;
        bus.rf_dataw = '0;
        if (w_pop) begin
            bus.rf_we    = 1'b1;
            bus.rf_addrw = r_addr[r_rd_ptr];
            bus.rf_dataw = r_data[r_rd_ptr];
        end else if (w_direct_a) begin
            bus.rf_we    = 1'b1;
            bus.rf_addrw = bus.a_addr;
            bus.rf_dataw = bus.a_data;
        end else if (w_direct_b) begin
            bus.rf_we    = 1'b1;
            bus.rf_addrw = bus.b_addr;
            bus.rf_dataw = bus.b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_addr[r_wr_ptr] <= bus.a_addr;
            r_data[r_wr_ptr] <= bus.a_data;
        end
        if (w_push_b) begin
            r_addr[w_wr_ptr_b] <= bus.b_addr;
            r_data[w_wr_ptr_b] <= bus.b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_a) + PW'(w_push_b);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_cnt    <= r_cnt + (PW+1)'(w_push_a) + (PW+1)'(w_push_b) - (PW+1)'(w_pop);
            r_ovf    <= r_ovf | ((bus.a_valid | bus.b_valid) & w_stall);
        end
    end

    assign w_raddr[0] = i_addra;
    assign w_raddr[1] = i_addrb;
    assign w_raddr[2] = i_addrc;

    // Scan oldest to newest so later matches overwrite; then A, then B as the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        for (int p = 0; p < 3; p++) begin
            w_hit[p] = 1'b0;
            w_fwd[p] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx = r_rd_ptr + PW'(k);
                if (((PW+1)'(k) < r_cnt) && (r_addr[idx] == w_raddr[p])) begin
                    w_hit[p] = 1'b1;
                    w_fwd[p] = r_data[idx];
                end
            end
            if (w_acc_a && (bus.a_addr == w_raddr[p])) begin
                w_hit[p] = 1'b1;
                w_fwd[p] = bus.a_data;
            end
            if (w_acc_b && (bus.b_addr == w_raddr[p])) begin
                w_hit[p] = 1'b1;
                w_fwd[p] = bus.b_data;
            end
        end
    end

    assign bus.wb_stall = w_stall;
    assign o_pend_cnt   = r_cnt;
    assign o_ovf        = r_ovf;
    assign o_hita       = w_hit[0];
    assign o_hitb       = w_hit[1];
    assign o_hitc       = w_hit[2];
    assign o_fwda       = w_fwd[0];
    assign o_fwdb       = w_fwd[1];
    assign o_fwdc       = w_fwd[2];
endmodule
